// File: rtl/avg_pool2d_stream_ctrl_if.sv
// Stream bundle for avg_pool2d_stream_ctrl: pixel input and average output.
interface avg_pool2d_stream_ctrl_if #(
    parameter int DW = 8
);
    logic [DW-1:0] data_in_0;
    logic          data_in_0_valid;
    logic          data_in_0_ready;
    logic [DW-1:0] data_out_0;
    logic          data_out_0_valid;
    logic          data_out_0_ready;
    logic          data_out_0_last;

    modport master (
        output data_in_0, data_in_0_valid, data_out_0_ready,
        input  data_in_0_ready, data_out_0, data_out_0_valid,
        input  data_out_0_last
    );

    modport slave (
        input  data_in_0, data_in_0_valid, data_out_0_ready,
        output data_in_0_ready, data_out_0, data_out_0_valid,
        output data_out_0_last
    );
endinterface

// File: rtl/avg_pool2d_stream_ctrl.sv
// Streaming 2D average pool: row-major pixels in, one floor-average
// per KERNEL_HEIGHT x KERNEL_WIDTH window out, 1 pixel/cycle.
module avg_pool2d_stream_ctrl #(
    parameter int DATA_IN_0_PRECISION_0  = 8,
    parameter int DATA_IN_0_PRECISION_1  = 3,
    parameter int DATA_IN_0_WIDTH        = 8,
    parameter int DATA_IN_0_HEIGHT       = 8,
    parameter int KERNEL_WIDTH           = 2,
    parameter int KERNEL_HEIGHT          = 2,
    parameter int DATA_OUT_0_WIDTH       = DATA_IN_0_WIDTH / KERNEL_WIDTH,
    parameter int DATA_OUT_0_HEIGHT      = DATA_IN_0_HEIGHT / KERNEL_HEIGHT,
    parameter int DATA_OUT_0_PRECISION_0 = 8
) (
    input logic                     clk,
    input logic                     rst,
    avg_pool2d_stream_ctrl_if.slave bus_io
);
    localparam int P0  = DATA_IN_0_PRECISION_0;
    localparam int KK  = KERNEL_WIDTH * KERNEL_HEIGHT;
    localparam int SH  = $clog2(KK);
    localparam int SW  = P0 + SH;
    localparam int REM = DATA_IN_0_HEIGHT % KERNEL_HEIGHT;
    localparam int CW  = $clog2(DATA_IN_0_WIDTH + 1);
    localparam int KCW = $clog2(KERNEL_WIDTH + 1);
    localparam int KRW = $clog2(KERNEL_HEIGHT + 1);
    localparam int OCW = $clog2(DATA_OUT_0_WIDTH + 1);
    localparam int ORW = $clog2(DATA_OUT_0_HEIGHT + 1);
    localparam int OIW = (DATA_OUT_0_WIDTH > 1) ? $clog2(DATA_OUT_0_WIDTH) : 1;

    localparam logic [CW-1:0]  COL_LAST = CW'(DATA_IN_0_WIDTH - 1);
    localparam logic [KCW-1:0] KC_LAST  = KCW'(KERNEL_WIDTH - 1);
    localparam logic [KRW-1:0] KR_LAST  = KRW'(KERNEL_HEIGHT - 1);
    localparam logic [KRW-1:0] REM_LAST = KRW'((REM > 0) ? REM - 1 : 0);
    localparam logic [OCW-1:0] OC_LIMIT = OCW'(DATA_OUT_0_WIDTH);
    localparam logic [OCW-1:0] OC_LAST  = OCW'(DATA_OUT_0_WIDTH - 1);
    localparam logic [ORW-1:0] OR_LAST  = ORW'(DATA_OUT_0_HEIGHT - 1);

    if ((KK & (KK - 1)) != 0) begin : g_kernel_chk
        $error("KERNEL_WIDTH*KERNEL_HEIGHT must be a power of two");
    end
    if (DATA_OUT_0_PRECISION_0 != P0 || DATA_IN_0_PRECISION_1 < 0) begin : g_prec_chk
        $error("output precision must equal input precision");
    end

    typedef enum logic {ACCUM, DISCARD} state_e;

    state_e         state_q;
    logic [CW-1:0]  col_q;
    logic [KCW-1:0] kc_q;
    logic [OCW-1:0] oc_q;
    logic [KRW-1:0] krow_q;
    logic [ORW-1:0] orow_q;
    logic           out_valid_q;
    logic           out_last_q;
    logic [P0-1:0]  out_data_q;

    logic signed [SW-1:0] psum_q [2**OIW];

    logic                 in_ready;
    logic                 fire;
    logic                 in_col;
    logic                 first;
    logic                 row_end;
    logic                 win_done;
    logic [OIW-1:0]       oc_idx;
    logic signed [SW-1:0] pix_ext;
    logic signed [SW-1:0] acc;
    logic [P0-1:0]        avg;

    assign in_ready = !(out_valid_q && !bus_io.data_out_0_ready);
    assign fire     = bus_io.data_in_0_valid && in_ready;
    assign in_col   = oc_q < OC_LIMIT;
    assign oc_idx   = oc_q[OIW-1:0];
    assign pix_ext  = SW'($signed(bus_io.data_in_0));
    assign acc      = psum_q[oc_idx] + pix_ext;
    assign avg      = P0'(acc >>> SH);
    assign first    = (krow_q == '0) && (kc_q == '0);
    assign row_end  = col_q == COL_LAST;
    assign win_done = (state_q == ACCUM) && in_col &&
                      (krow_q == KR_LAST) && (kc_q == KC_LAST);

    assign bus_io.data_in_0_ready  = in_ready;
    assign bus_io.data_out_0       = out_data_q;
    assign bus_io.data_out_0_valid = out_valid_q;
    assign bus_io.data_out_0_last  = out_last_q;

    // First pixel of a window overwrites, so no clear pass is needed.
    always_ff @(posedge clk) begin
        if (fire && state_q == ACCUM && in_col) begin
            psum_q[oc_idx] <= first ? pix_ext : acc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACCUM;
            col_q       <= '0;
            kc_q        <= '0;
            oc_q        <= '0;
            krow_q      <= '0;
            orow_q      <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            if (out_valid_q && bus_io.data_out_0_ready) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
            if (fire) begin
                if (win_done) begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= avg;
                    out_last_q  <= (orow_q == OR_LAST) && (oc_q == OC_LAST);
                end
                if (row_end) begin
                    col_q <= '0;
                    kc_q  <= '0;
                    oc_q  <= '0;
                    // In DISCARD, krow_q counts the leftover rows instead.
                    if (state_q == ACCUM) begin
                        if (krow_q == KR_LAST) begin
                            krow_q <= '0;
                            if (orow_q == OR_LAST) begin
                                orow_q <= '0;
                                if (REM > 0) state_q <= DISCARD;
                            end else begin
                                orow_q <= orow_q + ORW'(1);
                            end
                        end else begin
                            krow_q <= krow_q + KRW'(1);
                        end
                    end else if (krow_q == REM_LAST) begin
                        krow_q  <= '0;
                        state_q <= ACCUM;
                    end else begin
                        krow_q <= krow_q + KRW'(1);
                    end
                end else begin
                    col_q <= col_q + CW'(1);
                    if (kc_q == KC_LAST) begin
                        kc_q <= '0;
                        oc_q <= oc_q + OCW'(1);
                    end else begin
                        kc_q <= kc_q + KCW'(1);
                    end
                end
            end
        end
    end
endmodule

// File: doc/avg_pool2d_stream_ctrl.md
Name: avg_pool2d_stream_ctrl

Overview:
Streaming controller/datapath sequencer for 2D average pooling over one channel of a feature map arriving one pixel per beat in row-major order. Holds one row of per-output-column partial sums, sequences kernel-row and column counters, and emits each window average as soon as its last pixel is accepted. Sits between an upstream activation stream and downstream layers, replacing whole-tensor combinational pooling with a 1-pixel/cycle pipeline.

Parameters:
DATA_IN_0_PRECISION_0, 8, pixel width (signed two's complement fixed point)
DATA_IN_0_PRECISION_1, 3, fractional bits (pass-through, no effect on arithmetic)
DATA_IN_0_WIDTH, 8, input columns per row (>= KERNEL_WIDTH)
DATA_IN_0_HEIGHT, 8, input rows per frame (>= KERNEL_HEIGHT)
KERNEL_WIDTH, 2, window width; stride equals KERNEL_WIDTH
KERNEL_HEIGHT, 2, window height; stride equals KERNEL_HEIGHT
DATA_OUT_0_WIDTH, DATA_IN_0_WIDTH/KERNEL_WIDTH (floor), outputs per row
DATA_OUT_0_HEIGHT, DATA_IN_0_HEIGHT/KERNEL_HEIGHT (floor), output rows per frame
DATA_OUT_0_PRECISION_0, 8, must equal DATA_IN_0_PRECISION_0 (elaboration assert)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
data_in_0  input  DATA_IN_0_PRECISION_0  input pixel
data_in_0_valid  input  1  pixel valid
data_in_0_ready  output  1  pixel accepted when valid & ready
data_out_0  output  DATA_OUT_0_PRECISION_0  window average
data_out_0_valid  output  1  output valid
data_out_0_ready  input  1  downstream ready
data_out_0_last  output  1  high with final output of frame

Behaviour:
- Elaboration asserts: KERNEL_WIDTH*KERNEL_HEIGHT power of two; precisions match.
- Reset (sync, active-high): data_out_0_valid=0, data_out_0_last=0, data_out_0=0, all counters 0, state=ACCUM. Mid-frame reset abandons the frame; next accepted pixel is pixel (0,0) of a new frame. Partial-sum contents need not be cleared.
- Counters: col (0..DATA_IN_0_WIDTH-1), krow (0..KERNEL_HEIGHT-1), orow (0..DATA_OUT_0_HEIGHT-1); advance only on accepted beats. oc=col/KERNEL_WIDTH, kc=col%KERNEL_WIDTH.
- States: ACCUM -> pixels feed partial sums; DISCARD -> remainder rows (DATA_IN_0_HEIGHT%KERNEL_HEIGHT) accepted and dropped. ACCUM->DISCARD when last pixel of last kernel row of orow=DATA_OUT_0_HEIGHT-1 is accepted and remainder rows exist; else ->ACCUM with counters wrapped to frame start. DISCARD->ACCUM (frame start) on last pixel of last remainder row.
- Columns col >= DATA_OUT_0_WIDTH*KERNEL_WIDTH accepted and dropped in any state.
- Partial sums: width DATA_IN_0_PRECISION_0+log2(KH*KW), sign-extended. krow==0 & kc==0: psum[oc]<=pixel (overwrite, no clear pass); otherwise psum[oc]<=psum[oc]+pixel.
- Window complete when krow==KERNEL_HEIGHT-1 & kc==KERNEL_WIDTH-1 & in ACCUM: next cycle data_out_0=(psum[oc]+pixel)>>>log2(KH*KW) (arithmetic shift, floor toward -inf, low PRECISION_0 bits; never overflows), data_out_0_valid=1. Latency: 1 cycle from final window pixel acceptance.
- data_out_0_last=1 with output (DATA_OUT_0_HEIGHT-1, DATA_OUT_0_WIDTH-1).
- Handshake: data_in_0_ready = !(data_out_0_valid & !data_out_0_ready). Output register holds data/last stable while valid & !ready; clears valid on ready unless new result loads same cycle. Sustained throughput 1 pixel/cycle with out_ready=1.
- Accepting without valid: no state change. data_in_0 is don't-care when valid=0.

Test Plan:
- W=H=4, K=2x2, pixels 0..15 back-to-back, out_ready=1 -> outputs 2,4,10,12 (values 2.5,4.5 floored); last only on 12; each output 1 cycle after its final pixel; in_ready never drops.
- All pixels 8'hFF (-1) -> every output 8'hFF; window {-1,-1,-1,0} -> 8'hFF (floor of -0.75); all 8'h7F -> 8'h7F (no overflow).
- Backpressure: out_ready=0 from cycle of first output for 5 cycles -> in_ready=0 those cycles, data_out_0=2 held stable, no pixel lost; resume -> remaining 4,10,12 correct.
- W=H=5, pixels 0..24 -> outputs 3,5,13,15 (col 4 and row 4 discarded), last on 15; second frame 0..24 immediately after -> identical outputs.
- Reset asserted after 6 pixels of frame -> valid/last=0 next cycle; fresh frame 0..15 -> 2,4,10,12.
- Random valid/ready toggling (50%) over 20 frames, W=8,H=6 -> output stream matches golden floor-average model, last count = 20.
